// File: rtl/hs_npu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// hs_npu_mem_arbiter : N-port burst memory arbiter, one transaction in flight
// Rev 1.0
// ============================================================================
module hs_npu_mem_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int BURST_SIZE = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ARB_MODE   = 0,
    parameter int MAX_WAIT   = 3,
    localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int BW  = BURST_SIZE * DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            s_req_valid_i,
    input  logic [NUM_PORTS-1:0]            s_req_write_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_req_addr_i,
    input  logic [NUM_PORTS*BW-1:0]         s_req_wdata_i,
    output logic [NUM_PORTS-1:0]            s_req_ready_o,
    output logic [NUM_PORTS-1:0]            s_rsp_valid_o,
    output logic [BW-1:0]                   s_rsp_rdata_o,
    output logic                            m_req_valid_o,
    output logic                            m_req_write_o,
    output logic [ADDR_WIDTH-1:0]           m_req_addr_o,
    output logic [BW-1:0]                   m_req_wdata_o,
    input  logic                            m_req_ready_i,
    input  logic                            m_rsp_valid_i,
    input  logic [BW-1:0]                   m_rsp_rdata_i,
    output logic                            busy_o,
    output logic [IDW-1:0]                  grant_id_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [BW-1:0]          req_wdata_q, req_wdata_d;
    logic [IDW-1:0]         owner_q, owner_d;
    logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
    logic [BW-1:0]          rsp_rdata_q, rsp_rdata_d;

    logic                   w_any;
    logic                   w_accept;
    logic [IDW-1:0]         w_winner;
    logic                   w_sel_write;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [BW-1:0]          w_sel_wdata;

    assign w_any    = |s_req_valid_i;
    assign w_accept = (state_q == ST_IDLE) && w_any;

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    if (ARB_MODE == 0) begin : g_rr
        logic [IDW-1:0] last_q;
        int             w_rr_dist;
        int             w_rr_best;

        // Distance 0 is the port just after the last owner; nearest valid wins.
        always_comb begin
            w_winner  = '0;
            w_rr_best = NUM_PORTS;
            w_rr_dist = 0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_rr_dist = (p + NUM_PORTS - 1 - int'(last_q)) % NUM_PORTS;
                if (s_req_valid_i[p] && (w_rr_dist < w_rr_best)) begin
                    w_rr_best = w_rr_dist;
                    w_winner  = IDW'(p);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                last_q <= IDW'(NUM_PORTS - 1);
            end else if (w_accept) begin
                last_q <= w_winner;
            end
        end
    end else begin : g_fp
        localparam int WCW = $clog2(MAX_WAIT + 1);

        logic [NUM_PORTS*WCW-1:0] wait_q, wait_d;
        logic [IDW-1:0]           w_fp_any;
        logic [IDW-1:0]           w_fp_starved;
        logic                     w_fp_hit;

        // Descending scan so the lowest index is the last to overwrite.
        always_comb begin
            w_fp_any     = '0;
            w_fp_starved = '0;
            w_fp_hit     = 1'b0;
            for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                if (s_req_valid_i[p]) begin
                    w_fp_any = IDW'(p);
                    if (wait_q[p*WCW +: WCW] == WCW'(MAX_WAIT)) begin
                        w_fp_starved = IDW'(p);
                        w_fp_hit     = 1'b1;
                    end
                end
            end
            w_winner = w_fp_hit ? w_fp_starved : w_fp_any;
        end

        always_comb begin
            wait_d = wait_q;
            if (w_accept) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (!s_req_valid_i[p] || (w_winner == IDW'(p))) begin
                        wait_d[p*WCW +: WCW] = '0;
                    end else if (wait_q[p*WCW +: WCW] != WCW'(MAX_WAIT)) begin
                        wait_d[p*WCW +: WCW] = wait_q[p*WCW +: WCW] + WCW'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Request field mux and one-hot ready
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel_write   = 1'b0;
        w_sel_addr    = '0;
        w_sel_wdata   = '0;
        s_req_ready_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_winner == IDW'(p)) begin
                w_sel_write      = s_req_write_i[p];
                w_sel_addr       = s_req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata      = s_req_wdata_i[p*BW +: BW];
                s_req_ready_o[p] = w_accept;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (w_any)         state_d = ST_REQ;
            ST_REQ:      if (m_req_ready_i) state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: if (m_rsp_valid_i) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        owner_d     = owner_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = '0;
        if (w_accept) begin
            req_write_d = w_sel_write;
            req_addr_d  = w_sel_addr;
            req_wdata_d = w_sel_wdata;
            owner_d     = w_winner;
        end
        // Writes complete here too; their rdata is whatever the memory drove.
        if ((state_q == ST_WAIT_RSP) && m_rsp_valid_i) begin
            rsp_rdata_d = m_rsp_rdata_i;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rsp_valid_d[p] = (owner_q == IDW'(p));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign m_req_valid_o = (state_q == ST_REQ);
    assign m_req_write_o = req_write_q;
    assign m_req_addr_o  = req_addr_q;
    assign m_req_wdata_o = req_wdata_q;
    assign s_rsp_valid_o = rsp_valid_q;
    assign s_rsp_rdata_o = rsp_rdata_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign grant_id_o    = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_npu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_hs_npu_mem_arbiter : round-robin and fixed-priority arbiters vs. a model
// Rev 1.0
// ============================================================================
module tb_hs_npu_mem_arbiter;

    localparam int NP  = 4;
    localparam int BS  = 2;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MW  = 3;
    localparam int IDW = 2;
    localparam int BW  = BS * DW;

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_write;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*BW-1:0]  req_wdata;

    // Index 0: round-robin instance, index 1: fixed-priority instance
    logic [NP-1:0]     s_rdy   [2];
    logic [NP-1:0]     s_rspv  [2];
    logic [BW-1:0]     s_rdata [2];
    logic              mvalid  [2];
    logic              mwrite  [2];
    logic [AW-1:0]     maddr   [2];
    logic [BW-1:0]     mwdata  [2];
    logic              mready  [2];
    logic              mrspv   [2];
    logic [BW-1:0]     mrdata  [2];
    logic              busy    [2];
    logic [IDW-1:0]    gid     [2];

    hs_npu_mem_arbiter #(.NUM_PORTS(NP), .BURST_SIZE(BS), .DATA_WIDTH(DW),
                         .ADDR_WIDTH(AW), .ARB_MODE(0), .MAX_WAIT(MW)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .s_req_valid_i(req_valid), .s_req_write_i(req_write),
        .s_req_addr_i(req_addr), .s_req_wdata_i(req_wdata),
        .s_req_ready_o(s_rdy[0]), .s_rsp_valid_o(s_rspv[0]), .s_rsp_rdata_o(s_rdata[0]),
        .m_req_valid_o(mvalid[0]), .m_req_write_o(mwrite[0]), .m_req_addr_o(maddr[0]),
        .m_req_wdata_o(mwdata[0]), .m_req_ready_i(mready[0]), .m_rsp_valid_i(mrspv[0]),
        .m_rsp_rdata_i(mrdata[0]), .busy_o(busy[0]), .grant_id_o(gid[0])
    );

    hs_npu_mem_arbiter #(.NUM_PORTS(NP), .BURST_SIZE(BS), .DATA_WIDTH(DW),
                         .ADDR_WIDTH(AW), .ARB_MODE(1), .MAX_WAIT(MW)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .s_req_valid_i(req_valid), .s_req_write_i(req_write),
        .s_req_addr_i(req_addr), .s_req_wdata_i(req_wdata),
        .s_req_ready_o(s_rdy[1]), .s_rsp_valid_o(s_rspv[1]), .s_rsp_rdata_o(s_rdata[1]),
        .m_req_valid_o(mvalid[1]), .m_req_write_o(mwrite[1]), .m_req_addr_o(maddr[1]),
        .m_req_wdata_o(mwdata[1]), .m_req_ready_i(mready[1]), .m_rsp_valid_i(mrspv[1]),
        .m_rsp_rdata_i(mrdata[1]), .busy_o(busy[1]), .grant_id_o(gid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one outstanding transaction per arbiter
    // ------------------------------------------------------------------------
    bit            mb_busy  [2];
    bit            mb_sent  [2];
    bit            mb_pend  [2];
    int            mb_owner [2];
    int            mb_last  [2];
    int            mb_wait  [2][NP];
    logic          mb_wr    [2];
    logic [AW-1:0] mb_addr  [2];
    logic [BW-1:0] mb_wd    [2];
    logic [BW-1:0] mb_rd    [2];

    bit log_en;
    int glog_rr[$];
    int glog_fp[$];

    task automatic model_reset(input int d);
        mb_busy[d]  = 0;
        mb_sent[d]  = 0;
        mb_pend[d]  = 0;
        mb_owner[d] = 0;
        mb_last[d]  = NP - 1;
        mb_wr[d]    = 1'b0;
        mb_addr[d]  = '0;
        mb_wd[d]    = '0;
        mb_rd[d]    = '0;
        for (int p = 0; p < NP; p++) mb_wait[d][p] = 0;
    endtask

    function automatic int pick(input int d, input logic [NP-1:0] v);
        int r = -1;
        if (d == 0) begin
            for (int i = 1; i <= NP; i++)
                if (r < 0 && v[(mb_last[d] + i) % NP]) r = (mb_last[d] + i) % NP;
        end else begin
            for (int p = 0; p < NP; p++)
                if (r < 0 && v[p] && mb_wait[d][p] == MW) r = p;
            for (int p = 0; p < NP; p++)
                if (r < 0 && v[p]) r = p;
        end
        return r;
    endfunction

    always @(negedge clk) begin : model
        int            w;
        int            gi;
        logic [NP-1:0] erdy;
        logic [NP-1:0] ersp;
        bit            nxt_pend;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) model_reset(d);
            w    = pick(d, req_valid);
            erdy = (!mb_busy[d] && w >= 0) ? (NP'(1) << w) : '0;
            ersp = mb_pend[d] ? (NP'(1) << mb_owner[d]) : '0;
            check_eq($sformatf("d%0d ready", d), s_rdy[d], erdy);
            check_eq($sformatf("d%0d rsp_valid", d), s_rspv[d], ersp);
            if (mb_pend[d]) check_eq($sformatf("d%0d rsp_rdata", d), s_rdata[d], mb_rd[d]);
            check_eq($sformatf("d%0d busy", d), busy[d], mb_busy[d]);
            check_eq($sformatf("d%0d m_req_valid", d), mvalid[d], mb_busy[d] && !mb_sent[d]);
            check_eq($sformatf("d%0d grant_id", d), gid[d], mb_owner[d]);
            if (mb_busy[d] && !mb_sent[d]) begin
                check_eq($sformatf("d%0d m_req_write", d), mwrite[d], mb_wr[d]);
                check_eq($sformatf("d%0d m_req_addr", d), maddr[d], mb_addr[d]);
                check_eq($sformatf("d%0d m_req_wdata", d), mwdata[d], mb_wd[d]);
            end
            if (log_en && s_rdy[d] != '0) begin
                gi = -1;
                for (int p = 0; p < NP; p++) if (s_rdy[d][p]) gi = p;
                if (d == 0) glog_rr.push_back(gi);
                else        glog_fp.push_back(gi);
            end
            if (rst_n) begin
                nxt_pend = mb_busy[d] && mb_sent[d] && mrspv[d];
                if (nxt_pend) mb_rd[d] = mrdata[d];
                if (!mb_busy[d]) begin
                    if (w >= 0) begin
                        for (int p = 0; p < NP; p++) begin
                            if (p == w || !req_valid[p]) mb_wait[d][p] = 0;
                            else if (mb_wait[d][p] < MW) mb_wait[d][p] = mb_wait[d][p] + 1;
                        end
                        mb_owner[d] = w;
                        mb_last[d]  = w;
                        mb_wr[d]    = req_write[w];
                        mb_addr[d]  = req_addr[w*AW +: AW];
                        mb_wd[d]    = req_wdata[w*BW +: BW];
                        mb_busy[d]  = 1;
                        mb_sent[d]  = 0;
                    end
                end else if (!mb_sent[d]) begin
                    if (mready[d]) mb_sent[d] = 1;
                end else if (mrspv[d]) begin
                    mb_busy[d] = 0;
                end
                mb_pend[d] = nxt_pend;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int exp_rr_all[6]  = '{0, 1, 2, 3, 0, 1};
    int exp_fp_all[6]  = '{0, 0, 0, 1, 2, 3};
    int exp_rr_0_3[8]  = '{0, 3, 0, 3, 0, 3, 0, 3};
    int exp_fp_0_3[8]  = '{0, 0, 0, 3, 0, 0, 0, 3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ds(input logic rdy, input logic rv);
        for (int d = 0; d < 2; d++) begin
            mready[d] = rdy;
            mrspv[d]  = rv;
        end
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int d = 0; d < 2; d++) mrdata[d] = '0;
        set_ds(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        log_en = 0;
        clear_inputs();
        tick();
        tick();
        #2;
        for (int d = 0; d < 2; d++) begin
            check_eq("reset outputs", {s_rdy[d], s_rspv[d], mvalid[d], mwrite[d], busy[d], gid[d]}, '0);
            check_eq("reset addr/data", {maddr[d], mwdata[d], s_rdata[d]}, '0);
        end

        // Single read from port 2, response at cycle 4
        do_reset();
        req_valid = 4'b0100;
        req_addr[2*AW +: AW] = 32'h100;
        set_ds(1'b1, 1'b0);
        #2;
        for (int d = 0; d < 2; d++) check_eq("rd ready c0", s_rdy[d], 4'b0100);
        tick();
        req_valid = '0;
        #2;
        for (int d = 0; d < 2; d++) check_eq("rd mreq c1", {mvalid[d], maddr[d]}, {1'b1, 32'h100});
        tick();
        tick();
        tick();
        set_ds(1'b0, 1'b1);
        for (int d = 0; d < 2; d++) mrdata[d] = {32'hA, 32'hB};
        tick();
        set_ds(1'b0, 1'b0);
        #2;
        for (int d = 0; d < 2; d++) begin
            check_eq("rd rsp c5", s_rspv[d], 4'b0100);
            check_eq("rd rdata c5", s_rdata[d], {32'hA, 32'hB});
            check_eq("rd grant_id", gid[d], 2);
        end
        tick();

        // All ports continuously valid
        do_reset();
        glog_rr.delete();
        glog_fp.delete();
        log_en    = 1;
        req_valid = 4'b1111;
        set_ds(1'b1, 1'b1);
        repeat (18) tick();
        log_en    = 0;
        req_valid = '0;
        check_eq("rr all count", glog_rr.size(), 6);
        check_eq("fp all count", glog_fp.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < glog_rr.size()) check_eq($sformatf("rr all grant %0d", i), glog_rr[i], exp_rr_all[i]);
            if (i < glog_fp.size()) check_eq($sformatf("fp all grant %0d", i), glog_fp[i], exp_fp_all[i]);
        end

        // Ports 0 and 3 continuously valid: starvation guard
        do_reset();
        glog_rr.delete();
        glog_fp.delete();
        log_en    = 1;
        req_valid = 4'b1001;
        set_ds(1'b1, 1'b1);
        repeat (24) tick();
        log_en    = 0;
        req_valid = '0;
        check_eq("rr 0/3 count", glog_rr.size(), 8);
        check_eq("fp 0/3 count", glog_fp.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < glog_rr.size()) check_eq($sformatf("rr 0/3 grant %0d", i), glog_rr[i], exp_rr_0_3[i]);
            if (i < glog_fp.size()) check_eq($sformatf("fp 0/3 grant %0d", i), glog_fp[i], exp_fp_0_3[i]);
        end

        // Backpressure: downstream stalls 5 cycles while others request
        do_reset();
        req_valid = 4'b1000;
        req_write = 4'b1000;
        req_addr[3*AW +: AW]  = 32'h2000;
        req_wdata[3*BW +: BW] = {32'hDEAD_BEEF, 32'h0BAD_F00D};
        tick();
        req_valid = 4'b1111;
        repeat (5) begin
            #2;
            for (int d = 0; d < 2; d++) begin
                check_eq("bp ready", s_rdy[d], '0);
                check_eq("bp mreq", {mvalid[d], mwrite[d], maddr[d], mwdata[d]},
                         {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 32'h0BAD_F00D});
            end
            tick();
        end
        set_ds(1'b1, 1'b0);
        tick();
        set_ds(1'b0, 1'b1);
        #2;
        for (int d = 0; d < 2; d++) check_eq("bp ready wait", s_rdy[d], '0);
        tick();
        req_valid = '0;
        set_ds(1'b0, 1'b0);
        tick();

        // Write from port 1 with port 0 arriving during the response wait
        do_reset();
        req_valid = 4'b0010;
        req_write = 4'b0010;
        req_wdata[1*BW +: BW] = {32'h11, 32'h22};
        set_ds(1'b1, 1'b0);
        tick();
        req_valid = '0;
        #2;
        for (int d = 0; d < 2; d++) check_eq("wr wdata", {mwrite[d], mwdata[d]}, {1'b1, 32'h11, 32'h22});
        tick();
        set_ds(1'b0, 1'b1);
        req_valid = 4'b0001;
        req_write = '0;
        tick();
        set_ds(1'b0, 1'b0);
        #2;
        for (int d = 0; d < 2; d++) begin
            check_eq("wr rsp", s_rspv[d], 4'b0010);
            check_eq("wr overlap ready", s_rdy[d], 4'b0001);
        end
        tick();
        req_valid = '0;
        set_ds(1'b1, 1'b1);
        repeat (3) tick();
        set_ds(1'b0, 1'b0);
        tick();

        // Reset during the response wait
        do_reset();
        req_valid = 4'b1000;
        set_ds(1'b1, 1'b0);
        tick();
        req_valid = '0;
        tick();
        set_ds(1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        #2;
        for (int d = 0; d < 2; d++) begin
            check_eq("midrst outputs", {s_rdy[d], s_rspv[d], mvalid[d], busy[d], gid[d]}, '0);
            check_eq("midrst addr", maddr[d], '0);
        end
        rst_n = 1'b1;
        set_ds(1'b0, 1'b1);
        tick();
        tick();
        #2;
        for (int d = 0; d < 2; d++) check_eq("midrst stray rsp", s_rspv[d], '0);
        set_ds(1'b0, 1'b0);
        tick();

        // Randomized traffic, with occasional resets
        do_reset();
        repeat (3000) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            req_valid = NP'($urandom);
            req_write = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                req_addr[p*AW +: AW]  = $urandom;
                req_wdata[p*BW +: BW] = {$urandom, $urandom};
            end
            for (int d = 0; d < 2; d++) begin
                mready[d] = ($urandom_range(0, 3) != 0);
                mrspv[d]  = ($urandom_range(0, 2) == 0);
                mrdata[d] = {$urandom, $urandom};
            end
            tick();
        end
        rst_n = 1'b1;
        clear_inputs();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
